// File: rtl/ex_pkg.sv
// Shared execute-stage widths, op encodings and small helpers for the integer ALU.
package ex_pkg;
  localparam int XLEN      = 32;
  localparam int REG_TAG_W = 5;
  localparam int SHAMT_W   = 5;

  typedef logic [4:0] bit_op_t;    // one-hot {slt,sub,xor,or,and}
  typedef logic [2:0] shift_op_t;  // one-hot {sra,srl,sll}

  localparam bit_op_t BOP_AND = 5'b00001;
  localparam bit_op_t BOP_OR  = 5'b00010;
  localparam bit_op_t BOP_XOR = 5'b00100;
  localparam bit_op_t BOP_SUB = 5'b01000;
  localparam bit_op_t BOP_SLT = 5'b10000;

  localparam shift_op_t SOP_SLL = 3'b001;
  localparam shift_op_t SOP_SRL = 3'b010;
  localparam shift_op_t SOP_SRA = 3'b100;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } alu_state_t;

  function automatic logic is_onehot5(input bit_op_t v);
    return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
  endfunction

  function automatic logic is_onehot3(input shift_op_t v);
    return (v != 3'd0) && ((v & (v - 3'd1)) == 3'd0);
  endfunction

  // One bit position of movement, used by the iterative shifter
  function automatic logic [XLEN-1:0] shift_step(input logic [XLEN-1:0] v, input shift_op_t op);
    logic [XLEN-1:0] r;
    case (op)
      SOP_SLL: r = {v[XLEN-2:0], 1'b0};
      SOP_SRL: r = {1'b0, v[XLEN-1:1]};
      SOP_SRA: r = {v[XLEN-1], v[XLEN-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/int_alu_exec_if.sv
// Issue/result bundle between decode and the integer ALU execute unit.
interface int_alu_exec_if;
  import ex_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic                 add_en;
  logic                 bit_en;
  logic                 shift_en;
  bit_op_t              bit_op_en;
  shift_op_t            shift_op_en;
  logic                 slt_u;
  logic [XLEN-1:0]      src1;
  logic [XLEN-1:0]      src2;
  logic [REG_TAG_W-1:0] rd_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_result;
  logic [REG_TAG_W-1:0] out_rd;
  logic                 out_err;

  modport slave (
    input  in_valid, add_en, bit_en, shift_en, bit_op_en, shift_op_en,
           slt_u, src1, src2, rd_tag, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_err
  );

  modport master (
    output in_valid, add_en, bit_en, shift_en, bit_op_en, shift_op_en,
           slt_u, src1, src2, rd_tag, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_err
  );
endinterface

// File: rtl/int_shift_unit.sv
// Shifter for the integer ALU. Default build is a single-cycle barrel shifter;
// defining INT_ALU_ITER_SHIFT_EN selects a 1-bit/cycle engine with an IDLE/SHIFT FSM.
module int_shift_unit
  import ex_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  shift_op_t          i_op,
  input  logic [XLEN-1:0]    i_src,
  input  logic [SHAMT_W-1:0] i_amt,
  input  logic               i_out_free,
  output logic               o_busy,
  output logic               o_defer,
  output logic               o_done,
  output logic [XLEN-1:0]    o_result
);
`ifdef INT_ALU_ITER_SHIFT_EN
  alu_state_t         r_state;
  alu_state_t         w_state_nxt;
  logic [SHAMT_W-1:0] r_cnt;
  logic [SHAMT_W-1:0] w_cnt_nxt;
  logic [XLEN-1:0]    r_val;
  logic [XLEN-1:0]    w_val_nxt;
  logic [XLEN-1:0]    w_step;
  shift_op_t          r_op;
  shift_op_t          w_op_nxt;

  // State, remaining count and partially shifted operand
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= {SHAMT_W{1'b0}};
      r_val   <= {XLEN{1'b0}};
      r_op    <= 3'b000;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_val   <= w_val_nxt;
      r_op    <= w_op_nxt;
    end
  end

  // The last bit step feeds the output register directly, so count==1 means done
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_val_nxt   = r_val;
    w_op_nxt    = r_op;
    w_step      = shift_step(r_val, r_op);
    o_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && (i_amt != 5'd0)) begin
          w_state_nxt = SHIFT;
          w_cnt_nxt   = i_amt;
          w_val_nxt   = i_src;
          w_op_nxt    = i_op;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (r_cnt == 5'd1) begin
          o_done = 1'b1;
          if (i_out_free) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 5'd0;
          end else begin
            w_state_nxt = SHIFT;
          end
        end else begin
          w_val_nxt = w_step;
          w_cnt_nxt = r_cnt - 5'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 5'd0;
      end
    endcase
  end

  assign o_busy   = (r_state == SHIFT);
  assign o_defer  = (i_amt != 5'd0);
  assign o_result = o_busy ? w_step : i_src;
`else
  logic w_unused_ok;

  // Single-cycle barrel shift
  always_comb begin
    case (i_op)
      SOP_SLL: o_result = i_src << i_amt;
      SOP_SRL: o_result = i_src >> i_amt;
      SOP_SRA: o_result = $unsigned($signed(i_src) >>> i_amt);
      default: o_result = {XLEN{1'b0}};
    endcase
  end

  assign o_busy      = 1'b0;
  assign o_defer     = 1'b0;
  assign o_done      = 1'b0;
  assign w_unused_ok = &{1'b0, clk, rst_n, i_start, i_out_free};
`endif
endmodule

// File: rtl/int_alu_exec.sv
// Integer ALU execute unit: add, and/or/xor/sub/slt and shifts (via int_shift_unit).
// Shift implementation is selected by INT_ALU_ITER_SHIFT_EN (iterative when defined).
module int_alu_exec
  import ex_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  int_alu_exec_if.slave bus
);
  logic                 w_out_free;
  logic                 w_in_ready;
  logic                 w_accept;
  logic [1:0]           w_grp_cnt;
  logic                 w_legal;
  logic                 w_lt;
  logic                 w_is_shift;
  logic                 w_sh_start;
  logic                 w_sh_busy;
  logic                 w_sh_defer;
  logic                 w_sh_done;
  logic [XLEN-1:0]      w_sh_result;
  logic [XLEN-1:0]      w_bit_result;
  logic [XLEN-1:0]      w_alu_result;
  logic                 w_load_now;
  logic                 w_load_iter;
  logic                 w_load;
  logic [XLEN-1:0]      w_load_result;
  logic [REG_TAG_W-1:0] w_load_rd;
  logic                 w_load_err;

  logic                 r_out_valid;
  logic [XLEN-1:0]      r_out_result;
  logic [REG_TAG_W-1:0] r_out_rd;
  logic                 r_out_err;
  logic [REG_TAG_W-1:0] r_pend_rd;

  assign w_out_free   = !r_out_valid || bus.out_ready;
  assign w_in_ready   = rst_n && !w_sh_busy && w_out_free;
  assign w_accept     = bus.in_valid && w_in_ready;
  assign bus.in_ready = w_in_ready;

  // Exactly one group, and a one-hot op vector for bit/shift groups
  always_comb begin
    w_grp_cnt = {1'b0, bus.add_en} + {1'b0, bus.bit_en} + {1'b0, bus.shift_en};
    if (w_grp_cnt != 2'd1) begin
      w_legal = 1'b0;
    end else if (bus.add_en) begin
      w_legal = 1'b1;
    end else if (bus.bit_en) begin
      w_legal = is_onehot5(bus.bit_op_en);
    end else begin
      w_legal = is_onehot3(bus.shift_op_en);
    end
  end

  assign w_lt = bus.slt_u ? (bus.src1 < bus.src2)
                          : ($signed(bus.src1) < $signed(bus.src2));

  // Single-cycle result selection; illegal encodings produce zero
  always_comb begin
    case (bus.bit_op_en)
      BOP_AND: w_bit_result = bus.src1 & bus.src2;
      BOP_OR:  w_bit_result = bus.src1 | bus.src2;
      BOP_XOR: w_bit_result = bus.src1 ^ bus.src2;
      BOP_SUB: w_bit_result = bus.src1 - bus.src2;
      BOP_SLT: w_bit_result = {{(XLEN-1){1'b0}}, w_lt};
      default: w_bit_result = {XLEN{1'b0}};
    endcase
    if (!w_legal) begin
      w_alu_result = {XLEN{1'b0}};
    end else if (bus.add_en) begin
      w_alu_result = bus.src1 + bus.src2;
    end else if (bus.bit_en) begin
      w_alu_result = w_bit_result;
    end else begin
      w_alu_result = w_sh_result;
    end
  end

  assign w_is_shift = w_legal && bus.shift_en;
  assign w_sh_start = w_accept && w_is_shift;

  int_shift_unit u_shift (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_sh_start),
    .i_op       (bus.shift_op_en),
    .i_src      (bus.src1),
    .i_amt      (bus.src2[SHAMT_W-1:0]),
    .i_out_free (w_out_free),
    .o_busy     (w_sh_busy),
    .o_defer    (w_sh_defer),
    .o_done     (w_sh_done),
    .o_result   (w_sh_result)
  );

  // A deferred shift loads later from the shifter; everything else loads on accept
  assign w_load_now  = w_accept && !(w_is_shift && w_sh_defer);
  assign w_load_iter = w_sh_done && w_out_free;
  assign w_load      = w_load_now || w_load_iter;

  // Source of the value written into the output register
  always_comb begin
    if (w_load_iter) begin
      w_load_result = w_sh_result;
      w_load_rd     = r_pend_rd;
      w_load_err    = 1'b0;
    end else begin
      w_load_result = w_alu_result;
      w_load_rd     = bus.rd_tag;
      w_load_err    = !w_legal;
    end
  end

  // Destination tag of a shift still in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_rd <= {REG_TAG_W{1'b0}};
    end else if (w_sh_start) begin
      r_pend_rd <= bus.rd_tag;
    end
  end

  // Output register: payload only changes on load, so it holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= {XLEN{1'b0}};
      r_out_rd     <= {REG_TAG_W{1'b0}};
      r_out_err    <= 1'b0;
    end else if (w_load) begin
      r_out_valid  <= 1'b1;
      r_out_result <= w_load_result;
      r_out_rd     <= w_load_rd;
      r_out_err    <= w_load_err;
    end else if (bus.out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_out_result;
  assign bus.out_rd     = r_out_rd;
  assign bus.out_err    = r_out_err;
endmodule

// File: tb/tb_int_alu_exec.sv
// Self-checking bench for int_alu_exec: directed corner cases plus randomized ops
// scored in order against a behavioural model of the ALU.
module tb_int_alu_exec;
  import ex_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

`ifdef INT_ALU_ITER_SHIFT_EN
  localparam bit ITER = 1'b1;
`else
  localparam bit ITER = 1'b0;
`endif

  int_alu_exec_if bus();

  int_alu_exec dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural model: returns {err, result}
  function automatic logic [32:0] ref_model(input logic a, input logic b, input logic s,
                                            input logic [4:0] bop, input logic [2:0] sop,
                                            input logic su, input logic [31:0] x,
                                            input logic [31:0] y);
    int          groups;
    int          amt;
    logic [31:0] r;
    groups = int'(a) + int'(b) + int'(s);
    amt    = int'(y % 32);
    r      = 32'd0;
    if (groups != 1) return {1'b1, 32'd0};
    if (a) return {1'b0, x + y};
    if (b) begin
      if ($countones(bop) != 1) return {1'b1, 32'd0};
      if (bop == 5'b00001)      r = x & y;
      else if (bop == 5'b00010) r = x | y;
      else if (bop == 5'b00100) r = x ^ y;
      else if (bop == 5'b01000) r = x - y;
      else r = (su ? (x < y) : ($signed(x) < $signed(y))) ? 32'd1 : 32'd0;
      return {1'b0, r};
    end
    if ($countones(sop) != 1) return {1'b1, 32'd0};
    if (sop == 3'b001)      r = x << amt;
    else if (sop == 3'b010) r = x >> amt;
    else                    r = 32'($signed(x) >>> amt);
    return {1'b0, r};
  endfunction

  task automatic set_op(input logic a, input logic b, input logic s, input logic [4:0] bop,
                        input logic [2:0] sop, input logic su, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] rd);
    bus.add_en      = a;
    bus.bit_en      = b;
    bus.shift_en    = s;
    bus.bit_op_en   = bop;
    bus.shift_op_en = sop;
    bus.slt_u       = su;
    bus.src1        = x;
    bus.src2        = y;
    bus.rd_tag      = rd;
  endtask

  function automatic logic [37:0] cur_expect();
    return {bus.rd_tag, ref_model(bus.add_en, bus.bit_en, bus.shift_en, bus.bit_op_en,
                                  bus.shift_op_en, bus.slt_u, bus.src1, bus.src2)};
  endfunction

  task automatic drain();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Issue the op already on the bus; measure latency and in_ready-low cycles
  task automatic issue_and_wait(output int lat, output int rdy_low, output logic [37:0] obs,
                                output bit timeout);
    int n;
    n             = 0;
    rdy_low       = 0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      #1;
      if (!bus.in_ready) rdy_low++;
      @(negedge clk);
      lat++;
    end
    timeout = !bus.out_valid || (n >= 100);
    obs     = {bus.out_rd, bus.out_err, bus.out_result};
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_op(1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 32'd0, 32'd0, 5'd0);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
    end
    checks++;
    if ({bus.out_valid, bus.out_err, bus.out_rd, bus.out_result} !== 39'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b e=%b rd=%0d res=%h want all zero",
               bus.out_valid, bus.out_err, bus.out_rd, bus.out_result);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_add_wrap();
    drain();
    set_op(1'b1, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'h1, 5'd7);
    bus.in_valid = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap_ready: got %b want 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.out_valid, bus.out_rd, bus.out_err, bus.out_result} !== {1'b1, 5'd7, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL add_wrap: got v=%b rd=%0d e=%b res=%h want v=1 rd=7 e=0 res=00000000",
               bus.out_valid, bus.out_rd, bus.out_err, bus.out_result);
    end
  endtask

  task automatic test_slt();
    int          lat;
    int          low;
    logic [37:0] obs;
    bit          to;
    for (int u = 0; u < 2; u++) begin
      drain();
      set_op(1'b0, 1'b1, 1'b0, 5'b10000, 3'd0, u[0], 32'hFFFF_FFFF, 32'h1, 5'd2);
      issue_and_wait(lat, low, obs, to);
      checks++;
      if (to || obs !== {5'd2, 1'b0, (u == 0) ? 32'd1 : 32'd0}) begin
        errors++;
        $display("FAIL slt_u%0d: got %h timeout=%b want result %0d", u, obs, to, (u == 0) ? 1 : 0);
      end
    end
  endtask

  task automatic test_shift_latency();
    logic [31:0] srcs [3];
    logic [31:0] amts [3];
    logic [2:0]  ops  [3];
    logic [31:0] res  [3];
    int          lat;
    int          low;
    int          exp_lat;
    logic [37:0] obs;
    bit          to;
    srcs[0] = 32'h8000_0000; amts[0] = 32'd4;  ops[0] = 3'b100; res[0] = 32'hF800_0000;
    srcs[1] = 32'h8000_0000; amts[1] = 32'd31; ops[1] = 3'b010; res[1] = 32'h0000_0001;
    srcs[2] = 32'h1234_5678; amts[2] = 32'h20; ops[2] = 3'b001; res[2] = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      drain();
      set_op(1'b0, 1'b0, 1'b1, 5'd0, ops[i], 1'b0, srcs[i], amts[i], 5'(i + 10));
      issue_and_wait(lat, low, obs, to);
      exp_lat = ITER ? int'(amts[i] % 32) + 1 : 1;
      checks++;
      if (to || obs !== {5'(i + 10), 1'b0, res[i]}) begin
        errors++;
        $display("FAIL shift_result_%0d: got %h timeout=%b want res %h", i, obs, to, res[i]);
      end
      checks++;
      if (lat != exp_lat || low != exp_lat - 1) begin
        errors++;
        $display("FAIL shift_latency_%0d: got lat=%0d ready_low=%0d want lat=%0d ready_low=%0d",
                 i, lat, low, exp_lat, exp_lat - 1);
      end
    end
  endtask

  task automatic test_illegal();
    logic [2:0]  ens  [4];
    logic [4:0]  bops [4];
    logic [2:0]  sops [4];
    int          lat;
    int          low;
    logic [37:0] obs;
    bit          to;
    ens[0] = 3'b010; bops[0] = 5'b00011; sops[0] = 3'b001;
    ens[1] = 3'b011; bops[1] = 5'b00001; sops[1] = 3'b001;
    ens[2] = 3'b000; bops[2] = 5'b00001; sops[2] = 3'b001;
    ens[3] = 3'b001; bops[3] = 5'b00001; sops[3] = 3'b000;
    for (int i = 0; i < 4; i++) begin
      drain();
      set_op(ens[i][2], ens[i][1], ens[i][0], bops[i], sops[i], 1'b0,
             32'hDEAD_BEEF, 32'h0000_0005, 5'(i + 20));
      issue_and_wait(lat, low, obs, to);
      checks++;
      if (to || lat != 1 || obs !== {5'(i + 20), 1'b1, 32'd0}) begin
        errors++;
        $display("FAIL illegal_%0d: got %h lat=%0d timeout=%b want err=1 res=0 lat=1",
                 i, obs, lat, to);
      end
    end
  endtask

  task automatic test_stall();
    logic [37:0] exp_a;
    logic [37:0] exp_b;
    drain();
    set_op(1'b1, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, $urandom, $urandom, 5'd3);
    exp_a         = cur_expect();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    set_op(1'b0, 1'b1, 1'b0, 5'b00100, 3'd0, 1'b0, $urandom, $urandom, 5'd4);
    exp_b = cur_expect();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || {bus.out_rd, bus.out_err, bus.out_result} !== exp_a) begin
        errors++;
        $display("FAIL stall_hold_%0d: got v=%b %h want v=1 %h", i, bus.out_valid,
                 {bus.out_rd, bus.out_err, bus.out_result}, exp_a);
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_in_ready_%0d: got %b want 0", i, bus.in_ready);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || {bus.out_rd, bus.out_err, bus.out_result} !== exp_b) begin
      errors++;
      $display("FAIL stall_second_op: got v=%b %h want v=1 %h", bus.out_valid,
               {bus.out_rd, bus.out_err, bus.out_result}, exp_b);
    end
  endtask

  task automatic test_back_to_back();
    logic [37:0] exp_q [8];
    drain();
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.out_rd, bus.out_err, bus.out_result} !== exp_q[i-1]) begin
          errors++;
          $display("FAIL b2b_%0d: got v=%b %h want v=1 %h", i - 1, bus.out_valid,
                   {bus.out_rd, bus.out_err, bus.out_result}, exp_q[i-1]);
        end
      end
      if (i < 8) begin
        set_op(1'b1, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, $urandom, $urandom, 5'(i));
        exp_q[i]     = cur_expect();
        bus.in_valid = 1'b1;
        @(negedge clk);
      end else begin
        bus.in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    bit seen;
    drain();
    set_op(1'b0, 1'b0, 1'b1, 5'd0, 3'b001, 1'b0, 32'h0000_0001, 32'd20, 5'd9);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_shift_async: got v=%b ready=%b want 0 0", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_shift_idle: got ready=%b want 1", bus.in_ready);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_shift_ghost: got a result after release want none");
    end
  endtask

  task automatic rand_op();
    int          k;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  bop;
    logic [2:0]  sop;
    logic [2:0]  en;
    k = $urandom_range(0, 9);
    x = $urandom;
    y = $urandom;
    if ($urandom_range(0, 4) == 0) x = 32'hFFFF_FFFF;
    if ($urandom_range(0, 4) == 0) x = 32'h8000_0000;
    if ($urandom_range(0, 3) == 0) y = y & 32'h7;
    case (k)
      0, 1, 2: set_op(1'b1, 1'b0, 1'b0, 5'($urandom), 3'($urandom), 1'($urandom), x, y, 5'($urandom));
      3, 4, 5: begin
        bop = 5'b00001 << $urandom_range(0, 4);
        set_op(1'b0, 1'b1, 1'b0, bop, 3'($urandom), 1'($urandom), x, y, 5'($urandom));
      end
      6, 7: begin
        sop = 3'b001 << $urandom_range(0, 2);
        set_op(1'b0, 1'b0, 1'b1, 5'($urandom), sop, 1'($urandom), x, y, 5'($urandom));
      end
      8: begin
        en = 3'($urandom);
        set_op(en[2], en[1], en[0], 5'($urandom), 3'($urandom), 1'($urandom), x, y, 5'($urandom));
      end
      default: set_op(1'b0, 1'b1, 1'b0, 5'($urandom), 3'd0, 1'($urandom), x, y, 5'($urandom));
    endcase
  endtask

  task automatic test_random();
    logic [37:0] q [$];
    logic [37:0] exp_v;
    int          issued;
    int          cyc;
    bit          acc_last;
    issued   = 0;
    cyc      = 0;
    acc_last = 1'b0;
    drain();
    while ((issued < 150 || q.size() > 0 || bus.in_valid) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (acc_last) bus.in_valid = 1'b0;
      acc_last = 1'b0;
      if (!bus.in_valid && issued < 150 && $urandom_range(0, 3) != 0) begin
        rand_op();
        bus.in_valid = 1'b1;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL random_spurious: got result %h with nothing outstanding", bus.out_result);
        end else begin
          exp_v = q.pop_front();
          if ({bus.out_rd, bus.out_err, bus.out_result} !== exp_v) begin
            errors++;
            $display("FAIL random_result: got %h want %h", {bus.out_rd, bus.out_err, bus.out_result}, exp_v);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(cur_expect());
        issued++;
        acc_last = 1'b1;
      end
    end
    checks++;
    if (cyc >= 20000 || issued != 150) begin
      errors++;
      $display("FAIL random_timeout: got issued=%0d cycles=%0d pending=%0d want 150 issued, drained",
               issued, cyc, q.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add_wrap();
    test_slt();
    test_shift_latency();
    test_illegal();
    test_stall();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/int_alu_exec.md
INT_ALU_EXEC -- requirements
Module: int_alu_exec

Interface
REQ-001 SHALL have port: clk  in  1  single clock, rising edge.
REQ-002 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have port: in_valid  in  1  issued op valid.
REQ-004 SHALL have port: in_ready  out  1  unit accepts op this cycle.
REQ-005 SHALL have ports: add_en, bit_en, shift_en  in  1 each  group enables from decode.
REQ-006 SHALL have port: bit_op_en  in  5  one-hot {slt,sub,xor,or,and}.
REQ-007 SHALL have port: shift_op_en  in  3  one-hot {sra,srl,sll}.
REQ-008 SHALL have port: slt_u  in  1  unsigned compare for slt.
REQ-009 SHALL have ports: src1, src2  in  32 each  operands, immediate pre-muxed.
REQ-010 SHALL have port: rd_tag  in  5  destination tag, passed through.
REQ-011 SHALL have ports: out_valid  out  1; out_ready  in  1  result handshake.
REQ-012 SHALL have ports: out_result  out  32; out_rd  out  5; out_err  out  1  illegal encoding.

Function
REQ-013 SHALL accept an op when in_valid and in_ready are both high in the same cycle.
REQ-014 SHALL drive in_ready = (state==IDLE) & (!out_valid | out_ready).
REQ-015 SHALL compute add: src1+src2, mod 2^32.
REQ-016 SHALL compute bit ops: and/or/xor bitwise; sub = src1-src2 mod 2^32.
REQ-017 SHALL compute slt: result 1 if src1<src2 (signed, or unsigned when slt_u), else 0.
REQ-018 SHALL compute shifts with amount src2[4:0]: sll, srl zero-fill, sra sign-fill.
REQ-019 SHALL flag an op as illegal unless exactly one group enable is set and the selected group's op vector is one-hot (add needs none); an illegal op yields out_result=0, out_err=1.
REQ-020 SHALL register results: out_valid rises the cycle after acceptance (latency 1) for all non-iterative ops.
REQ-021 SHALL hold out_result/out_rd/out_err stable while out_valid & !out_ready.
REQ-022 SHALL sustain one op per cycle when out_ready stays high (accept and retire in the same cycle).
REQ-023 SHALL implement states IDLE, SHIFT: IDLE->SHIFT on accepted shift with amount>0 (iterative build only), SHIFT->IDLE when the remaining count reaches 0 and the output is loaded.
REQ-024 SHALL, in SHIFT, move one bit position per cycle, giving total latency amount+1 cycles; amount 0 completes in 1 cycle from IDLE.
REQ-025 SHALL hold in_ready low throughout SHIFT.
REQ-026 SHALL NOT drop a completed iterative result when out_ready is low; it stays in SHIFT until the output register is free.

Reset
REQ-027 SHALL on rst_n low, immediately and regardless of clk: state=IDLE, out_valid=0, out_result=0, out_rd=0, out_err=0, shift counter=0.
REQ-028 SHALL discard any in-flight shift on reset mid-operation; no result is produced after release.
REQ-029 SHALL keep in_ready low while rst_n is low.

Configuration
REQ-030 SHALL use macro INT_ALU_ITER_SHIFT_EN: defined -> iterative 1-bit/cycle shifter and SHIFT state (REQ-023..026); undefined -> single-cycle barrel shift, latency 1, SHIFT state absent.

Structure
REQ-031 SHALL take XLEN=32, REG_TAG_W=5 and typedefs bit_op_t (5 bit) and shift_op_t (3 bit) from shared package ex_pkg.
REQ-032 SHALL place shifting in sub-module int_shift_unit (barrel or iterative per REQ-030); add/bit/slt logic stays in int_alu_exec.

Verification
REQ-033 SHALL test: add 0xFFFFFFFF+0x1, rd 7 -> next cycle out_valid=1, out_result=0x0, out_rd=7, out_err=0.
REQ-034 SHALL test: slt src1=0xFFFFFFFF, src2=0x1, slt_u=0 -> 1; slt_u=1 -> 0.
REQ-035 SHALL test: sra 0x80000000 by 4 -> 0xF8000000; iterative build latency 5 cycles, in_ready low for 4 of them.
REQ-036 SHALL test: out_ready low for 3 cycles with result pending -> result held stable, in_ready=0, no second op lost; back-to-back 8 adds with out_ready=1 -> 8 results in 8 consecutive cycles.
REQ-037 SHALL test: bit_en with bit_op_en=0b00011 -> out_err=1, out_result=0.
REQ-038 SHALL test: rst_n asserted during sll by 20 -> out_valid=0 immediately, state IDLE, no result after release.
